// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle for the iterative divider.
// Master issues operands and start; slave returns status and results.
interface div_unit_if;
  logic        start;
  logic [31:0] RY;
  logic [31:0] BUSin;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] ZHI;
  logic [31:0] ZLO;

  modport master (
    output start, RY, BUSin,
    input  busy, done, div0, ZHI, ZLO
  );

  modport slave (
    input  start, RY, BUSin,
    output busy, done, div0, ZHI, ZLO
  );
endinterface

// File: rtl/div_unit.sv
// Signed 32-bit restoring divider: one step per clock, fixed 33-cycle latency.
// Remainder on ZHI takes the dividend's sign, quotient on ZLO truncates toward zero.
module div_unit (
  input logic        clk,
  input logic        clr,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [32:0] r_dvs;
  logic [31:0] r_ry;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic        r_done;
  logic        r_div0;
  logic [31:0] r_zhi;
  logic [31:0] r_zlo;

  logic [31:0] w_ry_mag;
  logic [32:0] w_bus_mag;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // Divisor magnitude in 33 bits so |0x80000000| stays exact; dividend magnitude fits unsigned.
  assign w_ry_mag  = bus.RY[31] ? (32'd0 - bus.RY) : bus.RY;
  assign w_bus_mag = bus.BUSin[31] ? (33'd0 - {1'b1, bus.BUSin}) : {1'b0, bus.BUSin};

  // Partial remainder is always below the divisor, so the 33-bit difference sign is exact.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - r_dvs;

  assign w_q_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (bus.start) w_state_next = StRun;
      StRun:  if (r_cnt == 6'd31) w_state_next = StFix;
      StFix:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt   <= 6'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 33'd0;
      r_ry    <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_zhi   <= 32'd0;
      r_zlo   <= 32'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_cnt   <= 6'd0;
            r_rem   <= 32'd0;
            r_quo   <= w_ry_mag;
            r_dvs   <= w_bus_mag;
            r_ry    <= bus.RY;
            r_neg_q <= bus.RY[31] ^ bus.BUSin[31];
            r_neg_r <= bus.RY[31];
            r_dz    <= (bus.BUSin == 32'd0);
          end
        end
        StRun: begin
          r_cnt <= r_cnt + 6'd1;
          if (!w_trial[32]) begin
            r_rem <= w_trial[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
        end
        StFix: begin
          r_done <= 1'b1;
          r_div0 <= r_dz;
          if (r_dz) begin
            r_zlo <= 32'hFFFF_FFFF;
            r_zhi <= r_ry;
          end else begin
            r_zlo <= w_q_fix;
            r_zhi <= w_r_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != StIdle);
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.ZHI  = r_zhi;
  assign bus.ZLO  = r_zlo;

endmodule
